dsp_biquad_sched: RTL and testbench
===================================

# dsp_biquad_sched

Time-shared stereo biquad engine that replaces the two free-running per-channel IIR instances in the audio path between the ADC reader and the volume/AGC stage. On each sample strobe it latches one left and one right sample and sequences the ten coefficient taps of two Direct Form I biquads through a single 16x16 signed multiply-accumulate unit. It emits both filtered samples with a one-cycle valid pulse. Coefficients are runtime inputs, so the preset/key logic can reconfigure the filters without resynthesis.

## Interface
Parameters:
- FRAC, 14, coefficient fraction bits (Q1.14 signed).
- ACC_W, 36, accumulator width.

Ports:
- iCLK_50  in  1  system clock, 50 MHz.
- iRST  in  1  reset; synchronous, active-high.
- iSTB  in  1  sample strobe, one-cycle pulse already synchronised to iCLK_50 (derived from the DACLRCK edge).
- iL, iR  in  16 signed  input samples, sampled on an accepted strobe.
- iCOEF_L, iCOEF_R  in  80  packed {b0,b1,b2,a1,a2}, 16-bit signed each, b0 in MSBs. Sampled on an accepted strobe.
- oL, oR  out  16 signed  filtered samples, held until the next oVALID.
- oVALID  out  1  one-cycle pulse when oL/oR update.
- oBUSY  out  1  high while a sample is in flight.
- oOVR  out  1  sticky overrun flag. Cleared only by iRST.

## Operation
- Filter per channel: y = b0·x0 + b1·x1 + b2·x2 − a1·y1 − a2·y2. Subtraction of the feedback terms is done in the accumulator, so a1/a2 use the textbook sign.
- FSM states: IDLE → MAC_L (5 cycles, tap index 0..4) → MAC_R (5 cycles) → SAT (1) → DONE (1) → IDLE.
- IDLE: iSTB=1 latches iL, iR, iCOEF_L, iCOEF_R, clears the accumulator and moves to MAC_L. iSTB=0 stays in IDLE.
- MAC_L/MAC_R: one product per cycle. Tap order is x0, x1, x2, y1, y2 with coefficients b0, b1, b2, a1, a2. Products are 32-bit signed and sign-extended to ACC_W. The last MAC_L cycle parks the left sum in a holding register and clears the accumulator for the right channel.
- SAT: each sum is arithmetic-shifted right by FRAC (floor), then saturated to [−32768, 32767].
  - Results are registered into oL/oR.
  - Histories update: x2←x1, x1←x0, y2←y1, y1←saturated y. Histories store saturated values only.
- DONE: oVALID=1 for this cycle only.
- Overrun: iSTB=1 in any state other than IDLE drops that sample, sets oOVR, and does not disturb the sample in flight.
- Reset (any state, including mid-sequence):
  - FSM to IDLE.
  - Accumulator, holding register and all eight history registers cleared to 0.
  - oL=oR=0, oVALID=0, oBUSY=0, oOVR=0.
  - The in-flight sample is discarded and no oVALID is emitted for it.
- Coefficients change only between samples. Changes on iCOEF_* while busy have no effect on the sample in flight.

## Timing
- Accepted strobe at cycle 0. MAC_L covers cycles 1–5, MAC_R cycles 6–10, SAT cycle 11.
- oL/oR are valid from cycle 12, with oVALID=1 in cycle 12.
- Fixed latency: 12 cycles from strobe to valid.
- oBUSY=1 in cycles 1–12. The next strobe is accepted from cycle 13.
- Throughput: one stereo sample per 13 cycles. At 48 kHz this is about 1/80 of the available 50 MHz budget.
- Strobe in cycle 12 (DONE) counts as an overrun.
- All outputs are registered. The only combinational path is the multiplier into the accumulator adder, one stage, within 20 ns.

## Structure
- Shared package dsp_pkg:
  - audio_t: logic signed [15:0].
  - coef_t: logic signed [15:0].
  - typedef biquad_coef_t: struct of b0, b1, b2, a1, a2.
  - FRAC constant.
  - sched_state_t enum: IDLE, MAC_L, MAC_R, SAT, DONE.
  - sat16() function.
- One sub-module, dsp_mac16. It is the single shared signed multiplier plus ACC_W accumulator, with inputs clr, en and sub. The scheduler owns the tap mux, histories and FSM.

## Test plan
- Passthrough: b0=16384, others 0, iL=1234, iR=−4321 → oL=1234, oR=−4321, oVALID exactly 12 cycles after the strobe.
- Recursion: left a1=−8192 (pole at +0.5), b0=16384; impulse iL=1000 then zeros on four strobes → oL=1000, 500, 250, 125. Right channel with b0=0 stays 0, showing channel independence.
- Saturation: b0=32767, iL=30000 → oL=32767; iL=−30000 → oL=−32768. Both histories store the clipped values.
- Overrun: strobes at cycle 0 and cycle 5 → exactly one oVALID at cycle 12, oOVR=1 and stays set; a strobe at cycle 13 is accepted normally.
- Reset mid-operation: iRST at cycle 6 → no oVALID, all outputs 0, oOVR=0. The next impulse reproduces the fresh recursion sequence (1000, 500, …), proving the histories were cleared.
- Coefficient hold: change iCOEF_L at cycle 3 → the current sample uses the old coefficients and the next sample uses the new ones.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared audio DSP types, fixed-point constants and the 16-bit saturation helper
// used by the time-shared biquad scheduler and its multiply-accumulate unit.
package dsp_pkg;

    localparam int FRAC     = 14;
    localparam int SAT_IN_W = 40;

    typedef logic signed [15:0] audio_t;
    typedef logic signed [15:0] coef_t;

    typedef struct packed {
        coef_t b0;
        coef_t b1;
        coef_t b2;
        coef_t a1;
        coef_t a2;
    } biquad_coef_t;

    typedef enum logic [2:0] {
        IDLE,
        MAC_L,
        MAC_R,
        SAT,
        DONE
    } sched_state_t;

    localparam logic signed [SAT_IN_W-1:0] SAT_MAX = 32767;
    localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -32768;

    function automatic audio_t sat16(input logic signed [SAT_IN_W-1:0] v);
        if (v > SAT_MAX)
            return 16'sh7fff;
        else if (v < SAT_MIN)
            return 16'sh8000;
        else
            return audio_t'(v[15:0]);
    endfunction

endpackage

// File: rtl/dsp_mac16.sv
// Single shared 16x16 signed multiplier feeding an ACC_W-bit add/subtract accumulator.
// sum is the combinational next value so the scheduler can park a finished channel sum.
module dsp_mac16
    import dsp_pkg::*;
#(
    parameter int ACC_W = 36
) (
    input  logic                    iCLK_50,
    input  logic                    iRST,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    sub,
    input  logic signed [15:0]      coef,
    input  logic signed [15:0]      data,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prodExt;

    assign prod    = 32'(coef) * 32'(data);
    assign prodExt = ACC_W'(prod);
    assign sum     = sub ? (acc - prodExt) : (acc + prodExt);

    always_ff @(posedge iCLK_50) begin
        if (iRST)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/dsp_biquad_sched.sv
// Time-shared stereo Direct Form I biquad: one strobe latches L/R samples and
// coefficients, then ten taps run through one MAC, followed by saturate and valid.
module dsp_biquad_sched
    import dsp_pkg::*;
#(
    parameter int FRAC  = dsp_pkg::FRAC,
    parameter int ACC_W = 36
) (
    input  logic               iCLK_50,
    input  logic               iRST,
    input  logic               iSTB,
    input  logic signed [15:0] iL,
    input  logic signed [15:0] iR,
    input  logic [79:0]        iCOEF_L,
    input  logic [79:0]        iCOEF_R,
    output logic signed [15:0] oL,
    output logic signed [15:0] oR,
    output logic               oVALID,
    output logic               oBUSY,
    output logic               oOVR
);

    sched_state_t state, stateNext;
    logic [2:0]   tap;

    biquad_coef_t coefL, coefR, chCoef;
    audio_t xL0, xL1, xL2, yL1, yL2;
    audio_t xR0, xR1, xR2, yR1, yR2;
    audio_t h0, h1, h2, h3, h4;

    logic signed [ACC_W-1:0] holdL, macAcc, macSum;
    audio_t mulData;
    coef_t  mulCoef;
    logic   macClr, macEn, macSub;
    logic   accept, parkL, doSat, ovrSet;
    audio_t yL, yR;

    always_ff @(posedge iCLK_50) begin
        if (iRST)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        macClr    = 1'b0;
        macEn     = 1'b0;
        macSub    = 1'b0;
        accept    = 1'b0;
        parkL     = 1'b0;
        doSat     = 1'b0;
        ovrSet    = iSTB && (state != IDLE);
        unique case (state)
            IDLE: begin
                if (iSTB) begin
                    accept    = 1'b1;
                    macClr    = 1'b1;
                    stateNext = MAC_L;
                end
            end
            MAC_L: begin
                macEn  = 1'b1;
                macSub = (tap >= 3'd3);
                // Last left tap: capture the finished sum and restart the MAC for the right channel.
                if (tap == 3'd4) begin
                    parkL     = 1'b1;
                    macClr    = 1'b1;
                    stateNext = MAC_R;
                end
            end
            MAC_R: begin
                macEn  = 1'b1;
                macSub = (tap >= 3'd3);
                if (tap == 3'd4)
                    stateNext = SAT;
            end
            SAT: begin
                doSat     = 1'b1;
                stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        if (state == MAC_R) begin
            chCoef = coefR;
            h0 = xR0; h1 = xR1; h2 = xR2; h3 = yR1; h4 = yR2;
        end else begin
            chCoef = coefL;
            h0 = xL0; h1 = xL1; h2 = xL2; h3 = yL1; h4 = yL2;
        end
        case (tap)
            3'd0:    begin mulData = h0; mulCoef = chCoef.b0; end
            3'd1:    begin mulData = h1; mulCoef = chCoef.b1; end
            3'd2:    begin mulData = h2; mulCoef = chCoef.b2; end
            3'd3:    begin mulData = h3; mulCoef = chCoef.a1; end
            default: begin mulData = h4; mulCoef = chCoef.a2; end
        endcase
    end

    dsp_mac16 #(.ACC_W(ACC_W)) uMac (
        .iCLK_50 (iCLK_50),
        .iRST    (iRST),
        .clr     (macClr),
        .en      (macEn),
        .sub     (macSub),
        .coef    (mulCoef),
        .data    (mulData),
        .acc     (macAcc),
        .sum     (macSum)
    );

    assign yL = sat16(SAT_IN_W'(holdL  >>> FRAC));
    assign yR = sat16(SAT_IN_W'(macAcc >>> FRAC));

    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            tap    <= '0;
            coefL  <= '0;
            coefR  <= '0;
            holdL  <= '0;
            xL0 <= '0; xL1 <= '0; xL2 <= '0; yL1 <= '0; yL2 <= '0;
            xR0 <= '0; xR1 <= '0; xR2 <= '0; yR1 <= '0; yR2 <= '0;
            oL     <= '0;
            oR     <= '0;
            oVALID <= 1'b0;
            oBUSY  <= 1'b0;
            oOVR   <= 1'b0;
        end else begin
            if ((state == MAC_L) || (state == MAC_R))
                tap <= (tap == 3'd4) ? 3'd0 : tap + 3'd1;
            else
                tap <= '0;
            if (accept) begin
                xL0   <= iL;
                xR0   <= iR;
                coefL <= iCOEF_L;
                coefR <= iCOEF_R;
            end
            if (parkL)
                holdL <= macSum;
            if (doSat) begin
                oL  <= yL;
                oR  <= yR;
                xL2 <= xL1; xL1 <= xL0; yL2 <= yL1; yL1 <= yL;
                xR2 <= xR1; xR1 <= xR0; yR2 <= yR1; yR1 <= yR;
            end
            oVALID <= doSat;
            oBUSY  <= (stateNext != IDLE);
            oOVR   <= oOVR | ovrSet;
        end
    end

endmodule

// File: tb/tb_dsp_biquad_sched.sv
// Directed bench for dsp_biquad_sched: a behavioural stereo biquad model fills a
// scoreboard at each accepted strobe; a negedge monitor pops it on every oVALID.
module tb_dsp_biquad_sched;

    logic               iCLK_50 = 1'b0;
    logic               iRST    = 1'b1;
    logic               iSTB    = 1'b0;
    logic signed [15:0] iL      = '0;
    logic signed [15:0] iR      = '0;
    logic [79:0]        iCOEF_L = '0;
    logic [79:0]        iCOEF_R = '0;
    logic signed [15:0] oL, oR;
    logic               oVALID, oBUSY, oOVR;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int s;

    typedef struct {
        int l;
        int r;
        int due;
    } exp_t;
    exp_t sb[$];

    int mx1[2], mx2[2], my1[2], my2[2];

    dsp_biquad_sched #(.FRAC(14), .ACC_W(36)) dut (
        .iCLK_50 (iCLK_50),
        .iRST    (iRST),
        .iSTB    (iSTB),
        .iL      (iL),
        .iR      (iR),
        .iCOEF_L (iCOEF_L),
        .iCOEF_R (iCOEF_R),
        .oL      (oL),
        .oR      (oR),
        .oVALID  (oVALID),
        .oBUSY   (oBUSY),
        .oOVR    (oOVR)
    );

    always #10 iCLK_50 = ~iCLK_50;
    always @(posedge iCLK_50) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] pk(input int b0, input int b1, input int b2, input int a1, input int a2);
        return {16'(b0), 16'(b1), 16'(b2), 16'(a1), 16'(a2)};
    endfunction

    // Reference: exact integer arithmetic, floor division by 2^14, clamp to 16 bits.
    function automatic int modelStep(input int ch, input int x, input logic [79:0] c);
        longint b0, b1, b2, a1, a2, acc;
        int     y;
        b0 = longint'($signed(c[79:64]));
        b1 = longint'($signed(c[63:48]));
        b2 = longint'($signed(c[47:32]));
        a1 = longint'($signed(c[31:16]));
        a2 = longint'($signed(c[15:0]));
        acc = b0 * x + b1 * mx1[ch] + b2 * mx2[ch] - a1 * my1[ch] - a2 * my2[ch];
        acc = acc >>> 14;
        if (acc > 32767)
            y = 32767;
        else if (acc < -32768)
            y = -32768;
        else
            y = int'(acc);
        mx2[ch] = mx1[ch];
        mx1[ch] = x;
        my2[ch] = my1[ch];
        my1[ch] = y;
        return y;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
        end
        sb.delete();
    endtask

    task automatic waitCyc(input int n);
        repeat (n) begin
            @(posedge iCLK_50);
            #1;
        end
    endtask

    task automatic gotoCyc(input int c);
        while (cyc < c) begin
            @(posedge iCLK_50);
            #1;
        end
    endtask

    task automatic doReset();
        iRST = 1'b1;
        iSTB = 1'b0;
        waitCyc(2);
        iRST = 1'b0;
        modelReset();
    endtask

    task automatic strobe(input int l, input int r, input bit accept);
        exp_t e;
        iL   = 16'(l);
        iR   = 16'(r);
        iSTB = 1'b1;
        if (accept) begin
            e.l   = modelStep(0, l, iCOEF_L);
            e.r   = modelStep(1, r, iCOEF_R);
            e.due = cyc + 12;
            sb.push_back(e);
        end
        @(posedge iCLK_50);
        #1;
        iSTB = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0) && (n < 40)) begin
            @(posedge iCLK_50);
            #1;
            n++;
        end
        check("drainTimeout", sb.size(), 0);
    endtask

    always @(negedge iCLK_50) begin : monitor
        exp_t e;
        if (oVALID) begin
            check("pendingOnValid", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("oL", oL, e.l);
                check("oR", oR, e.r);
                check("latency", cyc, e.due);
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        waitCyc(3);
        doReset();
        check("rstOL", oL, 0);
        check("rstOR", oR, 0);
        check("rstValid", oVALID, 0);
        check("rstBusy", oBUSY, 0);
        check("rstOvr", oOVR, 0);

        // Passthrough and exact latency
        iCOEF_L = pk(16384, 0, 0, 0, 0);
        iCOEF_R = pk(16384, 0, 0, 0, 0);
        s = cyc;
        strobe(1234, -4321, 1);
        check("busyC1", oBUSY, 1);
        gotoCyc(s + 11);
        check("noValidC11", oVALID, 0);
        gotoCyc(s + 12);
        check("validC12", oVALID, 1);
        check("busyC12", oBUSY, 1);
        gotoCyc(s + 13);
        check("noValidC13", oVALID, 0);
        check("idleC13", oBUSY, 0);
        drain();

        // Recursion with pole at +0.5; right channel b0=0 stays silent
        doReset();
        iCOEF_L = pk(16384, 0, 0, -8192, 0);
        iCOEF_R = pk(0, 0, 0, 0, 0);
        strobe(1000, 777, 1);
        drain();
        for (int k = 0; k < 3; k++) begin
            strobe(0, -500, 1);
            drain();
        end

        // Saturation, then a decaying sample that exposes the stored y history
        doReset();
        iCOEF_L = pk(32767, 0, 0, -4096, 0);
        iCOEF_R = pk(16384, 0, 0, 0, 0);
        strobe(30000, -30000, 1);
        drain();
        strobe(-30000, 30000, 1);
        drain();
        strobe(0, 0, 1);
        drain();

        // Overrun: second strobe mid-flight is dropped, flag is sticky
        doReset();
        iCOEF_L = pk(16384, 0, 0, 0, 0);
        iCOEF_R = pk(16384, 0, 0, 0, 0);
        s = cyc;
        strobe(100, -100, 1);
        gotoCyc(s + 5);
        strobe(200, -200, 0);
        check("ovrSet", oOVR, 1);
        gotoCyc(s + 12);
        check("ovrValidC12", oVALID, 1);
        gotoCyc(s + 13);
        strobe(300, -300, 1);
        check("acceptC13Busy", oBUSY, 1);
        check("ovrSticky", oOVR, 1);
        drain();
        check("ovrStickyEnd", oOVR, 1);

        // Reset mid-operation clears everything, histories included
        doReset();
        iCOEF_L = pk(16384, 0, 0, -8192, 0);
        iCOEF_R = pk(16384, 0, 0, 0, 0);
        strobe(1000, 50, 1);
        drain();
        s = cyc;
        strobe(0, 60, 1);
        gotoCyc(s + 2);
        strobe(0, 0, 0);
        gotoCyc(s + 6);
        iRST = 1'b1;
        waitCyc(1);
        iRST = 1'b0;
        modelReset();
        check("midRstOL", oL, 0);
        check("midRstOR", oR, 0);
        check("midRstValid", oVALID, 0);
        check("midRstBusy", oBUSY, 0);
        check("midRstOvr", oOVR, 0);
        waitCyc(14);
        check("midRstQuiet", oVALID, 0);
        strobe(1000, 0, 1);
        drain();
        strobe(0, 0, 1);
        drain();
        strobe(0, 0, 1);
        drain();

        // Coefficient hold: mid-flight change applies only to the next sample
        doReset();
        iCOEF_L = pk(16384, 0, 0, 0, 0);
        iCOEF_R = pk(16384, 0, 0, 0, 0);
        s = cyc;
        strobe(4000, 100, 1);
        gotoCyc(s + 3);
        iCOEF_L = pk(8192, 0, 0, 0, 0);
        iCOEF_R = pk(0, 0, 0, 0, 0);
        drain();
        strobe(4000, 100, 1);
        drain();

        waitCyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
